mux_rr_pipe: RTL and testbench



---
 rtl/mux_rr_pipe_if.sv | 27 ++
 rtl/mux_rr_pipe.sv | 120 ++++++++++++
 tb/tb_mux_rr_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mux_rr_pipe_if.sv
// Handshake bundle between N producer channels, the mux_rr_pipe block and its consumer.
// The master side drives the channel inputs and consumes the registered output.
interface mux_rr_pipe_if #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 4,
   parameter int SEL_W  = $clog2(N_CH)
);
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_valid;
   logic [N_CH-1:0]        in_ready;
   logic                   mode;
   logic [SEL_W-1:0]       sel;
   logic [DATA_W-1:0]      out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [SEL_W-1:0]       out_ch;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface

// File: rtl/mux_rr_pipe.sv
// Registered N-channel mux with explicit-select or round-robin arbitration and one output stage.
// Optional per-channel saturating transfer counters are enabled with MUX_GRANT_CNT_EN.
module mux_rr_pipe #(
   parameter  int N_CH   = 4,
   parameter  int DATA_W = 4,
   localparam int SEL_W  = $clog2(N_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef MUX_GRANT_CNT_EN
   input  logic                clr_cnt,
   output logic [N_CH*16-1:0]  grant_cnt,
`endif
   mux_rr_pipe_if.slave        bus
);

   logic [DATA_W-1:0] out_data_r;
   logic [SEL_W-1:0]  out_ch_r;
   logic              out_valid_r;
   logic [SEL_W-1:0]  last_r;

   logic              pipe_ready_s;
   logic              grant_vld_s;
   logic [SEL_W-1:0]  grant_s;
   logic [N_CH-1:0]   in_ready_s;
   logic              xfer_s;
   int                idx_s;

   assign pipe_ready_s = !out_valid_r || bus.out_ready;

   // Grant selection: explicit sel, or first requester after the last round-robin winner
   always_comb begin
      grant_vld_s = 1'b0;
      grant_s     = {SEL_W{1'b0}};
      idx_s       = 0;
      if (bus.mode == 1'b0) begin
         if (int'(bus.sel) < N_CH) begin
            grant_vld_s = 1'b1;
            grant_s     = bus.sel;
         end else begin
            grant_vld_s = 1'b0;
         end
      end else begin
         for (int k = 1; k <= N_CH; k++) begin
            idx_s = (int'(last_r) + k) % N_CH;
            if (!grant_vld_s && bus.in_valid[idx_s]) begin
               grant_vld_s = 1'b1;
               grant_s     = SEL_W'(idx_s);
            end else begin
               grant_vld_s = grant_vld_s;
            end
         end
      end
   end

   // One-hot ready toward the granted channel, suppressed while reset is asserted
   always_comb begin
      in_ready_s = {N_CH{1'b0}};
      if (rst_n && grant_vld_s && pipe_ready_s) begin
         in_ready_s[grant_s] = 1'b1;
      end else begin
         in_ready_s = {N_CH{1'b0}};
      end
   end

   assign xfer_s       = (in_ready_s[grant_s] == 1'b1) && (bus.in_valid[grant_s] == 1'b1);
   assign bus.in_ready = in_ready_s;

   // Output register: load on transfer, clear valid on drain, hold on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= {DATA_W{1'b0}};
         out_ch_r    <= {SEL_W{1'b0}};
         out_valid_r <= 1'b0;
      end else if (xfer_s) begin
         out_data_r  <= bus.in_data[int'(grant_s)*DATA_W +: DATA_W];
         out_ch_r    <= grant_s;
         out_valid_r <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // Round-robin pointer advances only on round-robin transfers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r <= SEL_W'(N_CH - 1);
      end else if (xfer_s && (bus.mode == 1'b1)) begin
         last_r <= grant_s;
      end
   end

   assign bus.out_data  = out_data_r;
   assign bus.out_ch    = out_ch_r;
   assign bus.out_valid = out_valid_r;

`ifdef MUX_GRANT_CNT_EN
   logic [15:0] cnt_r [N_CH];

   // Saturating per-channel transfer counters; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) cnt_r[i] <= 16'h0000;
      end else if (clr_cnt) begin
         for (int i = 0; i < N_CH; i++) cnt_r[i] <= 16'h0000;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (xfer_s && (int'(grant_s) == i) && (cnt_r[i] != 16'hFFFF)) begin
               cnt_r[i] <= cnt_r[i] + 16'h0001;
            end
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
      assign grant_cnt[g*16 +: 16] = cnt_r[g];
   end
`endif

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed self-checking bench for mux_rr_pipe (N_CH=4, DATA_W=4).
// Counter checks are compiled in only when MUX_GRANT_CNT_EN is defined.
module tb_mux_rr_pipe;

   logic clk = 1'b0;
   logic rst_n;
   int   n_assert;
   int   n_fail;
`ifdef MUX_GRANT_CNT_EN
   logic         clr_cnt;
   logic [63:0]  grant_cnt;
`endif

   logic [3:0] rr_all_ch [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
   logic [3:0] rr_all_d  [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB, 4'hC, 4'hD};
   logic [3:0] rr_odd_ch [4] = '{4'd1, 4'd3, 4'd1, 4'd3};
   logic [3:0] rr_odd_d  [4] = '{4'hB, 4'hD, 4'hB, 4'hD};

   mux_rr_pipe_if #(.N_CH(4), .DATA_W(4)) bus ();

   mux_rr_pipe #(.N_CH(4), .DATA_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MUX_GRANT_CNT_EN
      .clr_cnt   (clr_cnt),
      .grant_cnt (grant_cnt),
`endif
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert = n_assert + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
`ifdef MUX_GRANT_CNT_EN
      clr_cnt  = 1'b0;
`endif
      rst_n             = 1'b0;
      bus.in_data       = 16'hDCBA;
      bus.in_valid      = 4'hF;
      bus.mode          = 1'b1;
      bus.sel           = 2'd0;
      bus.out_ready     = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data",  {28'd0, bus.out_data},  32'd0);
      chk("rst_out_ch",    {30'd0, bus.out_ch},    32'd0);
      chk("rst_in_ready",  {28'd0, bus.in_ready},  32'd0);

      rst_n = 1'b1;
      #1;
      chk("rr_first_ready", {28'd0, bus.in_ready}, 32'h1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_all_ch",    {30'd0, bus.out_ch},    {28'd0, rr_all_ch[i]});
         chk("rr_all_data",  {28'd0, bus.out_data},  {28'd0, rr_all_d[i]});
         chk("rr_all_valid", {31'd0, bus.out_valid}, 32'd1);
      end

      bus.in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_odd_ch",   {30'd0, bus.out_ch},   {28'd0, rr_odd_ch[i]});
         chk("rr_odd_data", {28'd0, bus.out_data}, {28'd0, rr_odd_d[i]});
      end

      // Stall with ch3/D held; inputs change underneath it
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'hF;
      bus.in_data   = 16'h1234;
      #1;
      chk("stall_ready0", {28'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("stall_ch",    {30'd0, bus.out_ch},    32'd3);
         chk("stall_data",  {28'd0, bus.out_data},  32'hD);
         chk("stall_ready", {28'd0, bus.in_ready},  32'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("unstall_ready", {28'd0, bus.in_ready}, 32'h1);
      tick();
      chk("unstall_ch",    {30'd0, bus.out_ch},    32'd0);
      chk("unstall_data",  {28'd0, bus.out_data},  32'h4);
      chk("unstall_valid", {31'd0, bus.out_valid}, 32'd1);
      tick();
      chk("rr_to_ch1", {30'd0, bus.out_ch},   32'd1);
      chk("rr_to_d1",  {28'd0, bus.out_data}, 32'h3);

      // last=1: explicit sel=3, then back to round-robin resumes at ch2
      bus.mode = 1'b0;
      bus.sel  = 2'd3;
      #1;
      chk("sw_sel3_ready", {28'd0, bus.in_ready}, 32'h8);
      tick();
      chk("sw_sel3_ch",   {30'd0, bus.out_ch},   32'd3);
      chk("sw_sel3_data", {28'd0, bus.out_data}, 32'h1);
      bus.mode = 1'b1;
      #1;
      chk("sw_rr_ready", {28'd0, bus.in_ready}, 32'h4);
      tick();
      chk("sw_rr_ch",   {30'd0, bus.out_ch},   32'd2);
      chk("sw_rr_data", {28'd0, bus.out_data}, 32'h2);

      bus.in_data = 16'hDCBA;
      bus.mode    = 1'b0;
      bus.sel     = 2'd2;
      #1;
      chk("sel2_ready", {28'd0, bus.in_ready}, 32'h4);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sel2_ch",    {30'd0, bus.out_ch},    32'd2);
         chk("sel2_data",  {28'd0, bus.out_data},  32'hC);
         chk("sel2_valid", {31'd0, bus.out_valid}, 32'd1);
      end

      // Selected channel idle: ready shown but nothing loads, output drains
      bus.sel      = 2'd1;
      bus.in_valid = 4'b1101;
      #1;
      chk("idle_sel_ready", {28'd0, bus.in_ready}, 32'h2);
      tick();
      chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("drain_ch",    {30'd0, bus.out_ch},    32'd2);
      chk("drain_data",  {28'd0, bus.out_data},  32'hC);

      // last=2 from the earlier round-robin grant
      bus.in_valid = 4'hF;
      bus.mode     = 1'b1;
      tick();
      chk("pre_rst_ch", {30'd0, bus.out_ch}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_ready", {28'd0, bus.in_ready},  32'd0);
      rst_n = 1'b1;
      #1;
      chk("postrst_ready", {28'd0, bus.in_ready}, 32'h1);
      tick();
      chk("postrst_ch",   {30'd0, bus.out_ch},   32'd0);
      chk("postrst_data", {28'd0, bus.out_data}, 32'hA);

`ifdef MUX_GRANT_CNT_EN
      chk("cnt_one", {16'd0, grant_cnt[15:0]}, 32'h1);
      bus.mode     = 1'b0;
      bus.sel      = 2'd0;
      bus.in_valid = 4'h1;
      for (int i = 0; i < 70000; i++) tick();
      chk("cnt_sat",  {16'd0, grant_cnt[15:0]},  32'hFFFF);
      chk("cnt_ch1",  {16'd0, grant_cnt[31:16]}, 32'h0);
      clr_cnt = 1'b1;
      tick();
      chk("cnt_clr", {16'd0, grant_cnt[15:0]}, 32'h0);
      clr_cnt = 1'b0;
      tick();
      chk("cnt_after_clr", {16'd0, grant_cnt[15:0]}, 32'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
